// File: rtl/mul16_seq_pkg.sv
// Types shared by the sequential multiplier: FSM state enum built on the shared encodings.
package mul16_seq_pkg;
`include "mul16_seq_defs.vh"

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;
endpackage

// File: rtl/mul16_seq_if.sv
// Start/done handshake and operand/product bus between the core control unit and the multiplier.
interface mul16_seq_if #(
    parameter int WIDTH = mul16_seq_pkg::MUL16_SEQ_WIDTH_DEF
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul16_seq_defs.vh
// Shared state encodings and default operand width for the mul16_seq block.
`ifndef MUL16_SEQ_DEFS_VH
`define MUL16_SEQ_DEFS_VH
localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_RUN  = 2'd1;
localparam logic [1:0] ST_DONE = 2'd2;
localparam int MUL16_SEQ_WIDTH_DEF = 16;
`endif

// File: rtl/mul16_seq_dp.sv
// Shift-and-add datapath: multiplicand/multiplier shifters, gated adder, accumulator, product register.
// One partial-product step per step_i; load_i reloads operands, capture_i writes the final sum to product.
module mul16_seq_dp
    import mul16_seq_pkg::*;
#(
    parameter int WIDTH = MUL16_SEQ_WIDTH_DEF,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               capture_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               mplier_zero_o,
    output logic               count_last_o
);
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, product_q, product_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_sum;

    // Sum includes this step's partial product so capture sees the final value.
    assign acc_sum       = acc_q + (mcand_q & {2*WIDTH{mplier_q[0]}});
    assign mplier_zero_o = (mplier_q >> 1) == '0;
    assign count_last_o  = count_q == CW'(WIDTH - 1);
    assign product_o     = product_q;

    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            count_d  = '0;
        end else if (step_i) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
        end
        if (capture_i) begin
            product_d = acc_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end
endmodule

// File: rtl/mul16_seq.sv
// Sequential unsigned multiplier FSM (IDLE/RUN/DONE); WIDTH cycles start-to-done, start ignored while busy.
// Define MUL16_SEQ_EARLY_EXIT_EN to finish as soon as no multiplier bits remain.
module mul16_seq
    import mul16_seq_pkg::*;
#(
    parameter int WIDTH = MUL16_SEQ_WIDTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    mul16_seq_if.slave bus
);
`ifdef MUL16_SEQ_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    state_e state_q, state_d;
    logic   load, step, capture, finish;
    logic   mplier_zero, count_last;

    mul16_seq_dp #(.WIDTH(WIDTH)) u_dp (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load),
        .step_i        (step),
        .capture_i     (capture),
        .a_i           (bus.a),
        .b_i           (bus.b),
        .product_o     (bus.product),
        .mplier_zero_o (mplier_zero),
        .count_last_o  (count_last)
    );

    assign finish = count_last | (EARLY_EXIT & mplier_zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (finish) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A start seen here reloads directly, giving back-to-back operation.
                load    = bus.start;
                state_d = bus.start ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
endmodule

// File: tb/tb_mul16_seq.sv
// Randomized and directed checks of mul16_seq against an arithmetic reference (a*b, latency from b).
module tb_mul16_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mul16_seq_if #(.WIDTH(W)) bus ();
    mul16_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] av, input logic [W-1:0] bv);
        longint unsigned p;
        p = longint'(av) * longint'(bv);
        return p[2*W-1:0];
    endfunction

    function automatic int ref_lat(input logic [W-1:0] bv);
        int hb;
        hb = 0;
`ifdef MUL16_SEQ_EARLY_EXIT_EN
        for (int k = 0; k < W; k++) if (bv[k]) hb = k + 1;
        if (hb < 1) hb = 1;
`else
        hb = W;
`endif
        return hb;
    endfunction

    // Issues one start from IDLE; reports cycles to done, busy cycles, product at done, done one cycle later.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output int busy_cyc,
                         output logic [2*W-1:0] prod, output logic done_after);
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1; busy_cyc = 0; prod = 'x; done_after = 1'bx;
        if (bus.busy) busy_cyc++;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i; prod = bus.product;
                break;
            end
            if (bus.busy) busy_cyc++;
        end
        @(posedge clk); #1;
        done_after = bus.done;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.product !== '0) begin bad++; $display("FAIL reset_product got=%h want=0", bus.product); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc; logic [2*W-1:0] p; logic da;
        do_op(16'd3, 16'd5, lat, bc, p, da);
        total++; if (p !== 32'd15) begin bad++; $display("FAIL basic_product got=%0d want=15", p); end
        total++; if (lat !== ref_lat(16'd5)) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, ref_lat(16'd5)); end
        total++; if (bc !== ref_lat(16'd5)) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bc, ref_lat(16'd5)); end
        total++; if (da !== 1'b0) begin bad++; $display("FAIL basic_done_once got=%b want=0", da); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [2*W-1:0] p;
        lat = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus.done) break;
        end
        total++; if (bus.product !== 32'hFFFE0001) begin bad++; $display("FAIL max_product got=%h want=fffe0001", bus.product); end
        bus.start = 1'b1; bus.a = 16'd2; bus.b = 16'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_no_bubble busy=%b want=1", bus.busy); end
        total++; if (bus.product !== 32'hFFFE0001) begin bad++; $display("FAIL b2b_product_held got=%h want=fffe0001", bus.product); end
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat = i; break; end
        end
        p = bus.product;
        total++; if (p !== 32'd14) begin bad++; $display("FAIL b2b_product got=%0d want=14", p); end
        total++; if (lat !== ref_lat(16'd7)) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, ref_lat(16'd7)); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_operand();
        int lat, bc; logic [2*W-1:0] p; logic da;
        do_op(16'h1234, 16'd0, lat, bc, p, da);
        total++; if (p !== '0) begin bad++; $display("FAIL zero_b_product got=%h want=0", p); end
        total++; if (lat !== ref_lat(16'd0)) begin bad++; $display("FAIL zero_b_latency got=%0d want=%0d", lat, ref_lat(16'd0)); end
        do_op(16'd0, 16'hA5A5, lat, bc, p, da);
        total++; if (p !== '0) begin bad++; $display("FAIL zero_a_product got=%h want=0", p); end
        total++; if (lat !== ref_lat(16'hA5A5)) begin bad++; $display("FAIL zero_a_latency got=%0d want=%0d", lat, ref_lat(16'hA5A5)); end
    endtask

    task automatic test_start_ignored();
        int dones, first; logic [2*W-1:0] p;
        dones = 0; first = -1; p = 'x;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd10; bus.b = 16'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 2) begin bus.start = 1'b1; bus.a = 16'd9; bus.b = 16'd9; end
            if (i == 3) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                if (first < 0) begin first = i; p = bus.product; end
            end
        end
        total++; if (p !== 32'd40) begin bad++; $display("FAIL ignore_product got=%0d want=40", p); end
        total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
        total++; if (first !== ref_lat(16'd4)) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", first, ref_lat(16'd4)); end
    endtask

    task automatic test_async_reset();
        int lat, bc, dones; logic [2*W-1:0] p; logic da;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'd100; bus.b = 16'd100;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b want=0", bus.done); end
        total++; if (bus.product !== '0) begin bad++; $display("FAIL arst_product got=%h want=0", bus.product); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL arst_no_done got=%0d want=0", dones); end
        do_op(16'd100, 16'd100, lat, bc, p, da);
        total++; if (p !== 32'd10000) begin bad++; $display("FAIL arst_rerun_product got=%0d want=10000", p); end
        total++; if (lat !== ref_lat(16'd100)) begin bad++; $display("FAIL arst_rerun_latency got=%0d want=%0d", lat, ref_lat(16'd100)); end
    endtask

    task automatic test_early_exit();
        int lat, bc; logic [2*W-1:0] p; logic da;
        do_op(16'd7, 16'h0080, lat, bc, p, da);
        total++; if (p !== 32'd896) begin bad++; $display("FAIL exit_product got=%0d want=896", p); end
        total++; if (lat !== ref_lat(16'h0080)) begin bad++; $display("FAIL exit_latency got=%0d want=%0d", lat, ref_lat(16'h0080)); end
    endtask

    task automatic test_random();
        int lat, bc; logic [2*W-1:0] p; logic da;
        logic [W-1:0] av, bv;
        for (int n = 0; n < 16; n++) begin
            av = W'($urandom);
            bv = W'($urandom);
            if (n % 3 == 1) bv = bv >> $urandom_range(W - 1, 4);
            do_op(av, bv, lat, bc, p, da);
            total++; if (p !== ref_prod(av, bv)) begin bad++; $display("FAIL rand_product a=%h b=%h got=%h want=%h", av, bv, p, ref_prod(av, bv)); end
            total++; if (lat !== ref_lat(bv)) begin bad++; $display("FAIL rand_latency b=%h got=%0d want=%0d", bv, lat, ref_lat(bv)); end
            total++; if (da !== 1'b0) begin bad++; $display("FAIL rand_done_once b=%h got=%b want=0", bv, da); end
            repeat ($urandom_range(2, 0)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_operand();
        test_start_ignored();
        test_async_reset();
        test_early_exit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
